// File: rtl/id_stage_hz.sv
// id_stage_hz: MIPS decode stage with register file, control decode, sign
// extension, load-use hazard detection, a valid-tagged ID/EX register and a
// saturating stall-cycle counter.
//
// Build option: define ID_WB_BYPASS_EN to return writeback data to a
// same-cycle read of the register being written. When it is undefined the
// read returns the old register value.
module id_stage_hz #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              valid_in,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [8:0]        ex_ctrl,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Control word layout: {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead,
  // MemWrite, Branch, ALUOp[1:0]}.
  localparam int CTRL_MEMREAD = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam int NREGS = 2 ** REG_AW;

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs_addr;
  logic [REG_AW-1:0] rt_addr;
  logic [REG_AW-1:0] rd_addr;
  logic [DATA_W-1:0] imm_ext;
  logic [8:0]        ctrl_dec;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic              load_use;
  logic              bubble;
  logic [DATA_W-1:0] rf [NREGS];

  assign opcode  = instr_in[31:26];
  assign rs_addr = instr_in[21 +: REG_AW];
  assign rt_addr = instr_in[16 +: REG_AW];
  assign rd_addr = instr_in[11 +: REG_AW];
  assign imm_ext = {{(DATA_W-16){instr_in[15]}}, instr_in[15:0]};

  // Opcode to control word; unknown opcodes decode to all-zero control.
  always_comb begin
    ctrl_dec = 9'b0;
    unique case (opcode)
      OP_RTYPE: ctrl_dec = 9'b1_0_0_1_0_0_0_10;
      OP_LW:    ctrl_dec = 9'b0_1_1_1_1_0_0_00;
      OP_SW:    ctrl_dec = 9'b0_1_0_0_0_1_0_00;
      OP_BEQ:   ctrl_dec = 9'b0_0_0_0_0_0_1_01;
      OP_ADDI:  ctrl_dec = 9'b0_1_0_1_0_0_0_00;
      default:  ctrl_dec = 9'b0;
    endcase
  end

  // Register file write port; reset clears every entry, r0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (wb_we && (wb_addr != '0)) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // Register file read ports; r0 is hard-wired to zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
`ifdef ID_WB_BYPASS_EN
    if (rs_addr != '0) rdata1 = (wb_we && (wb_addr == rs_addr)) ? wb_data : rf[rs_addr];
    if (rt_addr != '0) rdata2 = (wb_we && (wb_addr == rt_addr)) ? wb_data : rf[rt_addr];
`else
    if (rs_addr != '0) rdata1 = rf[rs_addr];
    if (rt_addr != '0) rdata2 = rf[rt_addr];
`endif
  end

  // Load-use detection against the load sitting in ID/EX. rt is compared for
  // every opcode, so I-type instructions can stall needlessly; that is cheaper
  // than decoding which operands each opcode really uses.
  always_comb begin
    load_use = valid_in && ex_valid && ex_ctrl[CTRL_MEMREAD] && (ex_rt != '0) &&
               ((ex_rt == rs_addr) || (ex_rt == rt_addr));
    stall    = load_use && !flush;
  end

  assign bubble = flush || stall || !valid_in;

  // ID/EX register: data fields always load; the valid/control pair is
  // cleared for flushes, stalls and empty slots so a bubble never writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid  <= 1'b0;
      ex_ctrl   <= '0;
      ex_pc     <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_rd     <= '0;
    end else begin
      ex_valid  <= !bubble;
      ex_ctrl   <= bubble ? 9'b0 : ctrl_dec;
      ex_pc     <= pc_in;
      ex_rdata1 <= rdata1;
      ex_rdata2 <= rdata2;
      ex_imm    <= imm_ext;
      ex_rs     <= rs_addr;
      ex_rt     <= rt_addr;
      ex_rd     <= rd_addr;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_stage_hz.sv
// Scoreboard bench for id_stage_hz: the stimulus process pushes the expected
// ID/EX contents for every cycle it drives; the monitor pops one entry per
// clock edge and compares it with the registered outputs.
module tb_id_stage_hz;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        valid_in;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic        ex_valid;
  logic [8:0]  ex_ctrl;
  logic [31:0] ex_pc;
  logic [31:0] ex_rdata1;
  logic [31:0] ex_rdata2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_rd;
  logic [15:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  localparam logic [8:0] C_R    = 9'b1_0_0_1_0_0_0_10;
  localparam logic [8:0] C_LW   = 9'b0_1_1_1_1_0_0_00;
  localparam logic [8:0] C_SW   = 9'b0_1_0_0_0_1_0_00;
  localparam logic [8:0] C_BEQ  = 9'b0_0_0_0_0_0_1_01;
  localparam logic [8:0] C_ADDI = 9'b0_1_0_1_0_0_0_00;

  typedef struct {
    string       name;
    logic        valid;
    logic [8:0]  ctrl;
    logic        chk_data;
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  id_stage_hz dut (
    .clk       (clk),
    .reset     (reset),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .valid_in  (valid_in),
    .flush     (flush),
    .wb_we     (wb_we),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .stall     (stall),
    .ex_valid  (ex_valid),
    .ex_ctrl   (ex_ctrl),
    .ex_pc     (ex_pc),
    .ex_rdata1 (ex_rdata1),
    .ex_rdata2 (ex_rdata2),
    .ex_imm    (ex_imm),
    .ex_rs     (ex_rs),
    .ex_rt     (ex_rt),
    .ex_rd     (ex_rd),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled just after it.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".ex_valid"},  ex_valid,  e.valid);
      chk({e.name, ".ex_ctrl"},   ex_ctrl,   e.ctrl);
      chk({e.name, ".stall_cnt"}, stall_cnt, e.cnt);
      if (e.chk_data) begin
        chk({e.name, ".ex_pc"},     ex_pc,     e.pc);
        chk({e.name, ".ex_rdata1"}, ex_rdata1, e.r1);
        chk({e.name, ".ex_rdata2"}, ex_rdata2, e.r2);
        chk({e.name, ".ex_imm"},    ex_imm,    e.imm);
        chk({e.name, ".ex_rs"},     ex_rs,     e.rs);
        chk({e.name, ".ex_rt"},     ex_rt,     e.rt);
        chk({e.name, ".ex_rd"},     ex_rd,     e.rd);
      end
    end
  end

  // Drive one decode cycle, check the combinational stall, and queue the
  // ID/EX contents expected after the following rising edge.
  task automatic step(input string name, input logic rst, input logic [31:0] ins,
                      input logic [31:0] pc, input logic vin, input logic fl,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic chk_stall, input logic xstall,
                      input logic xvalid, input logic [8:0] xctrl, input logic chk_data,
                      input logic [31:0] xr1, input logic [31:0] xr2,
                      input logic [31:0] ximm, input logic [15:0] xcnt);
    exp_t e;
    @(negedge clk);
    reset = rst; instr_in = ins; pc_in = pc; valid_in = vin; flush = fl;
    wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    if (chk_stall) chk({name, ".stall"}, stall, xstall);
    e.name = name; e.valid = xvalid; e.ctrl = xctrl; e.chk_data = chk_data;
    e.pc = pc; e.r1 = xr1; e.r2 = xr2; e.imm = ximm;
    e.rs = ins[25:21]; e.rt = ins[20:16]; e.rd = ins[15:11]; e.cnt = xcnt;
    if (rst) begin
      e.pc = '0; e.imm = '0; e.rs = '0; e.rt = '0; e.rd = '0;
    end
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] byp;
`ifdef ID_WB_BYPASS_EN
    byp = 32'hA5;
`else
    byp = 32'h0;
`endif
    reset = 1'b1; instr_in = '0; pc_in = '0; valid_in = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;

    //   name      rst ins           pc     vin fl we wa wd            cs xs  v ctrl   cd r1        r2          imm          cnt
    step("rst0",   1, 32'h00A51820, 32'h4, 1, 0, 1, 5, 32'h77,       0, 0,  0, 9'h0,  1, 0,        0,          0,           0);
    step("rst1",   1, 32'h00A51820, 32'h4, 1, 0, 1, 5, 32'h77,       1, 0,  0, 9'h0,  1, 0,        0,          0,           0);
    step("rd0",    0, 32'h00A51820, 32'h100,1,0, 0, 0, 0,            1, 0,  1, C_R,   1, 0,        0,          32'h1820,    0);
    step("wr5",    0, 32'h00000000, 32'h0, 0, 0, 1, 5, 32'h1234,     1, 0,  0, 9'h0,  0, 0,        0,          0,           0);
    step("add",    0, 32'h00A51820, 32'h104,1,0, 0, 0, 0,            1, 0,  1, C_R,   1, 32'h1234, 32'h1234,   32'h1820,    0);
    step("lw1",    0, 32'h8C220000, 32'h108,1,0, 0, 0, 0,            1, 0,  1, C_LW,  1, 0,        0,          0,           0);
    step("use1",   0, 32'h00422020, 32'h10C,1,0, 0, 0, 0,            1, 1,  0, 9'h0,  0, 0,        0,          0,           1);
    step("use1b",  0, 32'h00422020, 32'h10C,1,0, 0, 0, 0,            1, 0,  1, C_R,   1, 0,        0,          32'h2020,    1);
    step("lw2",    0, 32'h8C220000, 32'h110,1,0, 0, 0, 0,            1, 0,  1, C_LW,  1, 0,        0,          0,           1);
    step("useflu", 0, 32'h00422020, 32'h114,1,1, 0, 0, 0,            1, 0,  0, 9'h0,  0, 0,        0,          0,           1);
    step("useaft", 0, 32'h00422020, 32'h10C,1,0, 0, 0, 0,            1, 0,  1, C_R,   1, 0,        0,          32'h2020,    1);
    step("addi",   0, 32'h20068000, 32'h118,1,0, 1, 0, 32'hDEAD,     1, 0,  1, C_ADDI,1, 0,        0,          32'hFFFF8000,1);
    step("rdr0",   0, 32'h00000820, 32'h11C,1,0, 0, 0, 0,            1, 0,  1, C_R,   1, 0,        0,          32'h0820,    1);
    step("byp",    0, 32'h00E04020, 32'h120,1,0, 1, 7, 32'hA5,       1, 0,  1, C_R,   1, byp,      0,          32'h4020,    1);
    step("rd7",    0, 32'h00E74820, 32'h124,1,0, 0, 0, 0,            1, 0,  1, C_R,   1, 32'hA5,   32'hA5,     32'h4820,    1);
    step("sw",     0, 32'hACE50004, 32'h128,1,0, 0, 0, 0,            1, 0,  1, C_SW,  1, 32'hA5,   32'h1234,   32'h4,       1);
    step("beq",    0, 32'h10A5FFFF, 32'h12C,1,0, 0, 0, 0,            1, 0,  1, C_BEQ, 1, 32'h1234, 32'h1234,   32'hFFFFFFFF,1);
    step("badop",  0, 32'hFC000000, 32'h130,1,0, 0, 0, 0,            1, 0,  1, 9'h0,  1, 0,        0,          0,           1);
    step("lw3",    0, 32'h8C0A0000, 32'h134,1,0, 0, 0, 0,            1, 0,  1, C_LW,  1, 0,        0,          0,           1);
    step("fstall", 0, 32'h200A0001, 32'h138,1,0, 0, 0, 0,            1, 1,  0, 9'h0,  0, 0,        0,          0,           2);
    step("fstallb",0, 32'h200A0001, 32'h138,1,0, 0, 0, 0,            1, 0,  1, C_ADDI,1, 0,        0,          32'h1,       2);
    step("lw4",    0, 32'h8C220000, 32'h13C,1,0, 0, 0, 0,            1, 0,  1, C_LW,  1, 0,        0,          0,           2);
    step("rstmid", 1, 32'h00422020, 32'h140,1,0, 1, 9, 32'h55,       1, 1,  0, 9'h0,  1, 0,        0,          0,           0);
    step("postrst",0, 32'h00422020, 32'h140,1,0, 0, 0, 0,            1, 0,  1, C_R,   1, 0,        0,          32'h2020,    0);
    step("clrrf",  0, 32'h00A51820, 32'h144,1,0, 0, 0, 0,            1, 0,  1, C_R,   1, 0,        0,          32'h1820,    0);
    step("idle",   0, 32'h00000000, 32'h148,0,0, 0, 0, 0,            1, 0,  0, 9'h0,  0, 0,        0,          0,           0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
